rv_decode_stage: RTL and testbench

Registered RISC-V RV32I/M instruction-decode stage that replaces the purely combinational main decoder. It sits between fetch and execute, and accepts one instruction plus PC per cycle over a valid/ready handshake. It produces a fully defined control bundle one cycle later, with no `x` outputs. A one-entry skid buffer keeps `in_ready` registered, and the block also flags and counts illegal encodings.

---
 rtl/rv_decode_stage.sv | 257 +++++++++++++++++++++++++
 tb/tb_rv_decode_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RV32I/M decode stage between fetch and execute.
// One beat (instruction + PC) per cycle over valid/ready. The decoded control
// bundle is registered and appears one cycle after the input fires. A one-entry
// skid buffer lets in_ready come straight from a flop. Illegal encodings are
// delivered like any other beat, carry only the Illegal flag, and are counted.
module rv_decode_stage #(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic             RegWrite,
    output logic             SrcASelect,
    output logic             ALUSrc,
    output logic             MemWrite,
    output logic             Branch,
    output logic             Jump,
    output logic             is_jalr,
    output logic             MulDiv,
    output logic             Illegal,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUOp,
    output logic [2:0]       BranchType,
    output logic [2:0]       LoadType,
    output logic [2:0]       StoreType,
    output logic [2:0]       ImmSrc,
    output logic [CNT_W-1:0] illegal_count
);

    typedef struct packed {
        logic       reg_write;
        logic       src_a_sel;
        logic       alu_src;
        logic       mem_write;
        logic [1:0] result_src;
        logic       branch;
        logic [1:0] alu_op;
        logic       jump;
        logic       is_jalr;
        logic       mul_div;
        logic       illegal;
        logic [2:0] branch_type;
        logic [2:0] load_type;
        logic [2:0] store_type;
        logic [2:0] imm_src;
    } ctrl_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic M_ON = (ENABLE_M != 0);

    ctrl_t           dec;
    logic            dec_illegal;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;

    ctrl_t           out_ctrl;
    ctrl_t           skid_ctrl;
    logic [31:0]     skid_instr;
    logic [XLEN-1:0] skid_pc;
    logic            skid_valid;

    logic            in_fire;
    logic            out_fire;
    logic            out_load;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    assign in_ready = !skid_valid;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    // The output register can take a new beat when it is empty or draining.
    assign out_load = !out_valid || out_ready;

    // Main decoder: opcode table plus funct3/funct7 legality; illegal beats
    // collapse to a bundle with only the Illegal flag set.
    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        case (opcode)
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b10;
                if (M_ON && funct7 == 7'b0000001) begin
                    dec.mul_div = 1'b1;
                end else if (funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
                    dec_illegal = 1'b1;
                end
            end
            OP_I_ALU: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = 2'b10;
                dec.imm_src   = IMM_I;
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b01;
                dec.load_type  = funct3;
                dec.imm_src    = IMM_I;
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
                    dec_illegal = 1'b1;
                end
            end
            OP_STORE: begin
                dec.alu_src    = 1'b1;
                dec.mem_write  = 1'b1;
                dec.store_type = funct3;
                dec.imm_src    = IMM_S;
                if (funct3 > 3'b010) begin
                    dec_illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                dec.branch      = 1'b1;
                dec.alu_op      = 2'b01;
                dec.branch_type = funct3;
                dec.imm_src     = IMM_B;
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    dec_illegal = 1'b1;
                end
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b10;
                dec.jump       = 1'b1;
                dec.imm_src    = IMM_J;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b10;
                dec.jump       = 1'b1;
                dec.is_jalr    = 1'b1;
                dec.imm_src    = IMM_I;
                if (funct3 != 3'b000) begin
                    dec_illegal = 1'b1;
                end
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = 2'b10;
                dec.imm_src   = IMM_U;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.src_a_sel = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = 2'b10;
                dec.imm_src   = IMM_U;
            end
            default: dec_illegal = 1'b1;
        endcase
        // Compressed-space encodings never reach a valid opcode above, but the
        // low bits are checked explicitly so the intent is obvious.
        if (in_instr[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end
        if (dec_illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    // Output register and skid buffer; flush empties both and wins over fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_ctrl   <= '0;
            out_instr  <= '0;
            out_pc     <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_load) begin
            if (skid_valid) begin
                // in_ready is low while the skid is full, so no input fires here.
                out_valid  <= 1'b1;
                out_ctrl   <= skid_ctrl;
                out_instr  <= skid_instr;
                out_pc     <= skid_pc;
                skid_valid <= 1'b0;
            end else if (in_fire) begin
                out_valid <= 1'b1;
                out_ctrl  <= dec;
                out_instr <= in_instr;
                out_pc    <= in_pc;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_ctrl  <= dec;
            skid_instr <= in_instr;
            skid_pc    <= in_pc;
        end
    end

    // Saturating count of illegal beats that leave the stage, flush or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_count <= '0;
        end else if (out_fire && out_ctrl.illegal && illegal_count != {CNT_W{1'b1}}) begin
            illegal_count <= illegal_count + CNT_W'(1);
        end
    end

    assign RegWrite   = out_ctrl.reg_write;
    assign SrcASelect = out_ctrl.src_a_sel;
    assign ALUSrc     = out_ctrl.alu_src;
    assign MemWrite   = out_ctrl.mem_write;
    assign ResultSrc  = out_ctrl.result_src;
    assign Branch     = out_ctrl.branch;
    assign ALUOp      = out_ctrl.alu_op;
    assign Jump       = out_ctrl.jump;
    assign is_jalr    = out_ctrl.is_jalr;
    assign MulDiv     = out_ctrl.mul_div;
    assign Illegal    = out_ctrl.illegal;
    assign BranchType = out_ctrl.branch_type;
    assign LoadType   = out_ctrl.load_type;
    assign StoreType  = out_ctrl.store_type;
    assign ImmSrc     = out_ctrl.imm_src;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage. dut1 decodes M (16-bit counter); dut2
// has M disabled and a 2-bit counter, shares the stimulus, has its own reset.
module tb_rv_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n, rst2_n;
    logic        flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;

    logic        in_ready1, out_valid1, in_ready2, out_valid2;
    logic [31:0] out_instr1, out_pc1, out_instr2, out_pc2;
    logic        rw1, sa1, as1, mw1, br1, j1, jr1, md1, il1;
    logic        rw2, sa2, as2, mw2, br2, j2, jr2, md2, il2;
    logic [1:0]  rs1, ao1, rs2, ao2;
    logic [2:0]  bt1, lt1, st1, is1, bt2, lt2, st2, is2;
    logic [15:0] cnt1;
    logic [1:0]  cnt2;
    logic [24:0] ctl1, ctl2;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    rv_decode_stage #(.XLEN(32), .ENABLE_M(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid1), .out_ready(out_ready), .out_instr(out_instr1), .out_pc(out_pc1),
        .RegWrite(rw1), .SrcASelect(sa1), .ALUSrc(as1), .MemWrite(mw1), .Branch(br1),
        .Jump(j1), .is_jalr(jr1), .MulDiv(md1), .Illegal(il1), .ResultSrc(rs1), .ALUOp(ao1),
        .BranchType(bt1), .LoadType(lt1), .StoreType(st1), .ImmSrc(is1),
        .illegal_count(cnt1)
    );

    rv_decode_stage #(.XLEN(32), .ENABLE_M(0), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst2_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2), .out_pc(out_pc2),
        .RegWrite(rw2), .SrcASelect(sa2), .ALUSrc(as2), .MemWrite(mw2), .Branch(br2),
        .Jump(j2), .is_jalr(jr2), .MulDiv(md2), .Illegal(il2), .ResultSrc(rs2), .ALUOp(ao2),
        .BranchType(bt2), .LoadType(lt2), .StoreType(st2), .ImmSrc(is2),
        .illegal_count(cnt2)
    );

    assign ctl1 = {rw1, sa1, as1, mw1, rs1, br1, ao1, j1, jr1, md1, il1, bt1, lt1, st1, is1};
    assign ctl2 = {rw2, sa2, as2, mw2, rs2, br2, ao2, j2, jr2, md2, il2, bt2, lt2, st2, is2};

    // Field order matches ctl1/ctl2 above.
    function automatic logic [24:0] mk(input logic rw, sa, as, mw, input logic [1:0] rs,
                                       input logic b, input logic [1:0] ao, input logic j, jr, md, il,
                                       input logic [2:0] bt, lt, st, is);
        return {rw, sa, as, mw, rs, b, ao, j, jr, md, il, bt, lt, st, is};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [31:0] sweep_instr [8];
    logic [24:0] sweep_ctl   [8];
    logic [24:0] c_ill, c_mul, c_lui, c_jal, c_auipc;
    logic [1:0]  exp_sat [6];

    initial begin
        sweep_instr[0] = 32'h00A00093; sweep_ctl[0] = mk(1,0,1,0,2'b00,0,2'b10,0,0,0,0,3'd0,3'd0,3'd0,3'b000);
        sweep_instr[1] = 32'h0000A103; sweep_ctl[1] = mk(1,0,1,0,2'b01,0,2'b00,0,0,0,0,3'd0,3'b010,3'd0,3'b000);
        sweep_instr[2] = 32'h00112023; sweep_ctl[2] = mk(0,0,1,1,2'b00,0,2'b00,0,0,0,0,3'd0,3'd0,3'b010,3'b001);
        sweep_instr[3] = 32'h00208463; sweep_ctl[3] = mk(0,0,0,0,2'b00,1,2'b01,0,0,0,0,3'b000,3'd0,3'd0,3'b010);
        sweep_instr[4] = 32'h008000EF; sweep_ctl[4] = mk(1,0,0,0,2'b10,0,2'b00,1,0,0,0,3'd0,3'd0,3'd0,3'b011);
        sweep_instr[5] = 32'h000080E7; sweep_ctl[5] = mk(1,0,1,0,2'b10,0,2'b00,1,1,0,0,3'd0,3'd0,3'd0,3'b000);
        sweep_instr[6] = 32'h12345137; sweep_ctl[6] = mk(1,0,1,0,2'b00,0,2'b10,0,0,0,0,3'd0,3'd0,3'd0,3'b100);
        sweep_instr[7] = 32'h00000197; sweep_ctl[7] = mk(1,1,1,0,2'b00,0,2'b10,0,0,0,0,3'd0,3'd0,3'd0,3'b100);
        c_ill   = mk(0,0,0,0,2'b00,0,2'b00,0,0,0,1,3'd0,3'd0,3'd0,3'd0);
        c_mul   = mk(1,0,0,0,2'b00,0,2'b10,0,0,1,0,3'd0,3'd0,3'd0,3'd0);
        c_lui   = sweep_ctl[6];
        c_jal   = sweep_ctl[4];
        c_auipc = sweep_ctl[7];
        exp_sat[0] = 2'd0; exp_sat[1] = 2'd1; exp_sat[2] = 2'd2;
        exp_sat[3] = 2'd3; exp_sat[4] = 2'd3; exp_sat[5] = 2'd3;

        rst_n = 1'b0; rst2_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        #12;
        rst_n = 1'b1; rst2_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_in_ready",  in_ready1,  1);
        chk("rst_out_valid", out_valid1, 0);
        chk("rst_ctl",       ctl1,       0);
        chk("rst_instr",     out_instr1, 0);
        chk("rst_pc",        out_pc1,    0);
        chk("rst_count",     cnt1,       0);
        chk("rst_count2",    cnt2,       0);

        // Opcode sweep, back to back
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_instr = sweep_instr[k];
            in_pc    = 32'h100 + 32'(4 * k);
            @(negedge clk);
            chk($sformatf("sweep%0d_valid", k), out_valid1, 1);
            chk($sformatf("sweep%0d_instr", k), out_instr1, sweep_instr[k]);
            chk($sformatf("sweep%0d_pc", k),    out_pc1,    32'h100 + 32'(4 * k));
            chk($sformatf("sweep%0d_ctl", k),   ctl1,       sweep_ctl[k]);
            chk($sformatf("sweep%0d_ready", k), in_ready1,  1);
        end
        chk("sweep_ctl_m_off", ctl2, sweep_ctl[7]);

        // M extension and illegal counting
        in_instr = 32'h022081B3; in_pc = 32'h120;
        @(negedge clk);
        chk("mul_ctl_m_on",  ctl1, c_mul);
        chk("mul_ctl_m_off", ctl2, c_ill);
        chk("mul_cnt",       cnt1, 0);
        in_instr = 32'hFFFFFFFF; in_pc = 32'h124;
        @(negedge clk);
        chk("ffff_ctl",  ctl1, c_ill);
        chk("ffff_cnt",  cnt1, 0);
        chk("mul_cnt2",  cnt2, 1);
        in_instr = 32'h0000B1A3; in_pc = 32'h128;
        @(negedge clk);
        chk("st011_ctl", ctl1, c_ill);
        chk("st011_pc",  out_pc1, 32'h128);
        chk("ffff_cnt1", cnt1, 1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("idle_valid", out_valid1, 0);
        chk("st011_cnt2", cnt1, 2);

        // Backpressure: A, B accepted, C stalls, then drains in order
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h12345137; in_pc = 32'h200;
        @(negedge clk);
        chk("bp_a_ready", in_ready1, 1);
        chk("bp_a_pc",    out_pc1,   32'h200);
        in_instr = 32'h008000EF; in_pc = 32'h204;
        @(negedge clk);
        chk("bp_b_ready", in_ready1, 0);
        chk("bp_b_hold",  out_pc1,   32'h200);
        in_instr = 32'h00000197; in_pc = 32'h208;
        @(negedge clk);
        chk("bp_c_ready", in_ready1, 0);
        chk("bp_c_hold",  out_pc1,   32'h200);
        chk("bp_c_ctl",   ctl1,      c_lui);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_out_b",     out_pc1,   32'h204);
        chk("bp_out_b_ctl", ctl1,      c_jal);
        chk("bp_rise",      in_ready1, 1);
        @(negedge clk);
        chk("bp_out_c",     out_pc1,   32'h208);
        chk("bp_out_c_ctl", ctl1,      c_auipc);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drained", out_valid1, 0);

        // Flush with two illegal beats buffered
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = 32'h300;
        @(negedge clk);
        in_instr = 32'h0000B1A3; in_pc = 32'h304;
        @(negedge clk);
        chk("fl_full", in_ready1, 0);
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("fl_valid", out_valid1, 0);
        chk("fl_ready", in_ready1,  1);
        chk("fl_cnt",   cnt1,       2);
        in_valid = 1'b1; in_instr = 32'h00A00093; in_pc = 32'h310;
        @(negedge clk);
        chk("fl_drop_in", out_valid1, 0);
        // Illegal beat firing on the output during flush still counts
        flush = 1'b0; out_ready = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = 32'h320;
        @(negedge clk);
        chk("fl_ill_loaded", ctl1, c_ill);
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("fl_fire_valid", out_valid1, 0);
        chk("fl_fire_cnt",   cnt1,       3);
        flush = 1'b0;

        // Saturation on the 2-bit counter
        #1 rst2_n = 1'b0;
        #1 chk("sat_rst", cnt2, 0);
        rst2_n = 1'b1;
        in_valid = 1'b1; in_instr = 32'hFFFFFFFF;
        for (int k = 0; k < 6; k++) begin
            in_pc = 32'h400 + 32'(4 * k);
            @(negedge clk);
            chk($sformatf("sat%0d_cnt", k), cnt2, exp_sat[k]);
        end
        chk("sat_ill", il2, 1);

        // Asynchronous reset mid-stream, checked before any clock edge
        #2 rst_n = 1'b0; rst2_n = 1'b0;
        #1;
        chk("arst_valid1", out_valid1, 0);
        chk("arst_cnt1",   cnt1,       0);
        chk("arst_valid2", out_valid2, 0);
        chk("arst_cnt2",   cnt2,       0);
        chk("arst_ready",  in_ready1,  1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
